// File: rtl/ide_pkg.sv
// -----------------------------------------------------------------------------
// ide_pkg
// Shared constants for the IDE/ATA drive emulator: task-file register
// addresses, command codes, status and error bits, sector geometry and the
// transfer FSM state type.
// No ports (package).
// -----------------------------------------------------------------------------
package ide_pkg;

   // Task-file register addresses; 1 and 7 mean different things on read and write
   localparam logic [2:0] REG_DATA     = 3'd0;
   localparam logic [2:0] REG_ERROR    = 3'd1;   // read
   localparam logic [2:0] REG_FEATURES = 3'd1;   // write
   localparam logic [2:0] REG_COUNT    = 3'd2;
   localparam logic [2:0] REG_SECTOR   = 3'd3;
   localparam logic [2:0] REG_CYL_LO   = 3'd4;
   localparam logic [2:0] REG_CYL_HI   = 3'd5;
   localparam logic [2:0] REG_HEAD     = 3'd6;
   localparam logic [2:0] REG_STATUS   = 3'd7;   // read
   localparam logic [2:0] REG_COMMAND  = 3'd7;   // write

   // Command codes
   localparam logic [7:0] CMD_READ_SECTORS  = 8'h20;
   localparam logic [7:0] CMD_WRITE_SECTORS = 8'h30;

   // Status register bits
   localparam logic [7:0] STS_BSY  = 8'h80;
   localparam logic [7:0] STS_DRDY = 8'h40;
   localparam logic [7:0] STS_DRQ  = 8'h08;
   localparam logic [7:0] STS_ERR  = 8'h01;

   // Error register values
   localparam logic [7:0] ERR_NONE  = 8'h00;
   localparam logic [7:0] ERR_DIAG  = 8'h01;   // post-reset diagnostic "no error"
   localparam logic [7:0] ERR_ABRT  = 8'h04;
   localparam logic [7:0] ERR_IDNF  = 8'h10;

   // Sector geometry
   localparam int SECTOR_BYTES = 512;

   // Reset values of the task-file registers
   localparam logic [7:0] RST_COUNT  = 8'h01;
   localparam logic [7:0] RST_SECTOR = 8'h01;
   localparam logic [7:0] RST_HEAD   = 8'hE0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,   // DRDY, waiting for a command
      ST_BUSY = 2'd1,   // BSY, preparing the next sector
      ST_XFER = 2'd2    // DRQ, moving sector bytes over the data register
   } ide_state_t;

   // Status byte assembled from the FSM view; DRDY is shown whenever not busy
   function automatic logic [7:0] status_byte(input logic bsy, input logic drq,
                                              input logic err);
      logic [7:0] s;
      s = 8'h00;
      if (bsy) s = s | STS_BSY;
      else     s = s | STS_DRDY;
      if (drq) s = s | STS_DRQ;
      if (err) s = s | STS_ERR;
      return s;
   endfunction

endpackage

// File: rtl/ide_sector_ram.sv
// -----------------------------------------------------------------------------
// ide_sector_ram
// SECTORS x 512 byte sector store, synchronous write, asynchronous read.
// With INIT_FILE empty the store presents byte(lba,off) = off[7:0] ^ lba[7:0]:
// the array holds data XOR that pattern and powers up all-zero, so the pattern
// appears without any load step and survives any number of drive resets.
// With INIT_FILE set the array is read raw.
//
// Ports:
//   clk    in   clock, write on rising edge
//   we     in   write enable
//   lba    in   LBA_W-bit sector index
//   off    in   9-bit byte offset inside the sector
//   wdata  in   8-bit write data
//   rdata  out  8-bit read data (combinational)
// -----------------------------------------------------------------------------
module ide_sector_ram
   import ide_pkg::*;
#(
   parameter int SECTORS   = 4,
   parameter int LBA_W     = 2,
   parameter     INIT_FILE = ""
) (
   input  logic             clk,
   input  logic             we,
   input  logic [LBA_W-1:0] lba,
   input  logic [8:0]       off,
   input  logic [7:0]       wdata,
   output logic [7:0]       rdata
);

   localparam int DEPTH       = SECTORS * SECTOR_BYTES;
   localparam bit USE_PATTERN = (INIT_FILE == "");

   logic [7:0]       mem [DEPTH] = '{default: 8'h00};
   logic [LBA_W+8:0] addr;
   logic [7:0]       mask;

   assign addr = {lba, off};

   // Pattern overlay only applies to the built-in image
   assign mask = USE_PATTERN ? (off[7:0] ^ 8'(lba)) : 8'h00;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata ^ mask;
      end
   end

   assign rdata = mem[addr] ^ mask;

endmodule

// File: rtl/ide_drive.sv
// -----------------------------------------------------------------------------
// ide_drive
// 8-bit IDE/ATA disk emulator. Exposes the eight task-file registers over a
// chip-enable / read / write strobe bus and serves READ SECTORS (0x20) with
// byte-wide PIO from an internal sector store.
//
// Build option: define IDE_WRITE_EN to accept WRITE SECTORS (0x30); without
// it 0x30 aborts like any unknown command and the store is read-only.
//
// Ports:
//   clk       in   system clock, rising edge
//   arst      in   asynchronous active-high reset
//   ce_n      in   chip enable, active low
//   oe_n      in   read strobe, active low
//   we_n      in   write strobe, active low
//   address   in   3-bit task-file register select
//   data_in   in   8-bit write data
//   data_out  out  8-bit read data, high impedance unless ce_n=0 and oe_n=0
// -----------------------------------------------------------------------------
module ide_drive
   import ide_pkg::*;
#(
   parameter int SECTORS     = 4,
   parameter int BUSY_CYCLES = 2,
   parameter     INIT_FILE   = ""
) (
   input  logic       clk,
   input  logic       arst,
   input  logic       ce_n,
   input  logic       oe_n,
   input  logic       we_n,
   input  logic [2:0] address,
   input  logic [7:0] data_in,
   output logic [7:0] data_out
);

   localparam int              LBA_W     = (SECTORS > 1) ? $clog2(SECTORS) : 1;
   localparam int              CNT_W     = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;
   localparam logic [CNT_W-1:0] BUSY_LOAD = CNT_W'(BUSY_CYCLES - 1);
   localparam logic [27:0]     LBA_LIMIT = 28'(SECTORS);

   // ---------------------------------------------------------------- state
   ide_state_t       state_reg, state_next;
   logic             err_reg;
   logic [7:0]       error_reg;
   logic [7:0]       features_reg;
   logic [7:0]       count_reg;
   logic [7:0]       sector_reg;
   logic [7:0]       cyl_lo_reg;
   logic [7:0]       cyl_hi_reg;
   logic [7:0]       head_reg;
   logic [8:0]       ptr_reg;
   logic [CNT_W-1:0] busy_cnt_reg;
`ifdef IDE_WRITE_EN
   logic             write_mode_reg;
`endif

   // ---------------------------------------------------------------- decode
   logic        wr_strobe, rd_strobe;
   logic        bsy, drq;
   logic        tf_write, cmd_write, cmd_is_xfer;
   logic        cmd_xfer, cmd_idnf, cmd_abort;
   logic        byte_take, sector_done, more_sectors, next_in_range;
   logic        start_busy;
   logic [27:0] lba_cur, lba_inc;
   logic        ram_we;
   logic [7:0]  ram_rdata;
   logic [7:0]  read_mux;
   logic        features_unused;

   assign wr_strobe = !ce_n && !we_n;
   assign rd_strobe = !ce_n && !oe_n;
   assign bsy       = (state_reg == ST_BUSY);
   assign drq       = (state_reg == ST_XFER);

   // Register writes are locked out while busy; commands also while DRQ
   assign tf_write  = wr_strobe && !bsy;
   assign cmd_write = wr_strobe && (address == REG_COMMAND) && !bsy && !drq;

`ifdef IDE_WRITE_EN
   assign cmd_is_xfer = (data_in == CMD_READ_SECTORS) || (data_in == CMD_WRITE_SECTORS);
   // In write mode only write strobes move the pointer, in read mode only reads
   assign byte_take   = drq && (address == REG_DATA) &&
                        (write_mode_reg ? wr_strobe : rd_strobe);
   assign ram_we      = byte_take && write_mode_reg;
`else
   assign cmd_is_xfer = (data_in == CMD_READ_SECTORS);
   assign byte_take   = drq && (address == REG_DATA) && rd_strobe;
   assign ram_we      = 1'b0;
`endif

   assign lba_cur       = {head_reg[3:0], cyl_hi_reg, cyl_lo_reg, sector_reg};
   assign lba_inc       = lba_cur + 28'd1;
   assign sector_done   = byte_take && (ptr_reg == 9'd511);
   // Count 0 stands for 256 sectors, so only a count of 1 ends the command
   assign more_sectors  = (count_reg != 8'd1);
   // A multi-sector run that walks off the end of the store stops with IDNF
   assign next_in_range = (lba_inc < LBA_LIMIT);

   // Features are latched for host compatibility but select no behaviour
   assign features_unused = ^features_reg;

   // ---------------------------------------------------------------- FSM
   always_comb begin
      state_next = state_reg;
      start_busy = 1'b0;
      cmd_xfer   = 1'b0;
      cmd_idnf   = 1'b0;
      cmd_abort  = 1'b0;

      if (cmd_write) begin
         if (cmd_is_xfer) begin
            if (lba_cur < LBA_LIMIT) cmd_xfer = 1'b1;
            else                     cmd_idnf = 1'b1;
         end else begin
            cmd_abort = 1'b1;
         end
      end

      case (state_reg)
         ST_IDLE: begin
            if (cmd_xfer) begin
               state_next = ST_BUSY;
               start_busy = 1'b1;
            end
         end
         ST_BUSY: begin
            if (busy_cnt_reg == '0) state_next = ST_XFER;
         end
         ST_XFER: begin
            if (sector_done) begin
               if (more_sectors && next_in_range) begin
                  state_next = ST_BUSY;
                  start_busy = 1'b1;
               end else begin
                  state_next = ST_IDLE;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_reg    <= ST_IDLE;
         err_reg      <= 1'b0;
         error_reg    <= ERR_DIAG;
         features_reg <= 8'h00;
         count_reg    <= RST_COUNT;
         sector_reg   <= RST_SECTOR;
         cyl_lo_reg   <= 8'h00;
         cyl_hi_reg   <= 8'h00;
         head_reg     <= RST_HEAD;
         ptr_reg      <= 9'd0;
         busy_cnt_reg <= '0;
`ifdef IDE_WRITE_EN
         write_mode_reg <= 1'b0;
`endif
      end else begin
         state_reg <= state_next;

         if (tf_write) begin
            case (address)
               REG_FEATURES: features_reg <= data_in;
               REG_COUNT:    count_reg    <= data_in;
               REG_SECTOR:   sector_reg   <= data_in;
               REG_CYL_LO:   cyl_lo_reg   <= data_in;
               REG_CYL_HI:   cyl_hi_reg   <= data_in;
               REG_HEAD:     head_reg     <= data_in;
               default: ;
            endcase
         end

         if (cmd_xfer) begin
            err_reg   <= 1'b0;
            error_reg <= ERR_NONE;
`ifdef IDE_WRITE_EN
            write_mode_reg <= (data_in == CMD_WRITE_SECTORS);
`endif
         end
         if (cmd_idnf) begin
            err_reg   <= 1'b1;
            error_reg <= ERR_IDNF;
         end
         if (cmd_abort) begin
            err_reg   <= 1'b1;
            error_reg <= ERR_ABRT;
         end

         if (start_busy) begin
            busy_cnt_reg <= BUSY_LOAD;
            ptr_reg      <= 9'd0;
         end else if (bsy && (busy_cnt_reg != '0)) begin
            busy_cnt_reg <= busy_cnt_reg - 1'b1;
         end

         // The pointer wraps 511 -> 0 on its own at the end of a sector
         if (byte_take) begin
            ptr_reg <= ptr_reg + 9'd1;
         end

         // Sector bookkeeping wins over a same-cycle host write to these regs
         if (sector_done) begin
            count_reg     <= count_reg - 8'd1;
            sector_reg    <= lba_inc[7:0];
            cyl_lo_reg    <= lba_inc[15:8];
            cyl_hi_reg    <= lba_inc[23:16];
            head_reg[3:0] <= lba_inc[27:24];
            if (more_sectors && !next_in_range) begin
               err_reg   <= 1'b1;
               error_reg <= ERR_IDNF;
            end
         end
      end
   end

   // ---------------------------------------------------------------- store
   ide_sector_ram #(
      .SECTORS   (SECTORS),
      .LBA_W     (LBA_W),
      .INIT_FILE (INIT_FILE)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .lba   (lba_cur[LBA_W-1:0]),
      .off   (ptr_reg),
      .wdata (data_in),
      .rdata (ram_rdata)
   );

   // ---------------------------------------------------------------- read bus
   always_comb begin
      read_mux = 8'h00;
      case (address)
         REG_DATA:   read_mux = drq ? ram_rdata : 8'h00;
         REG_ERROR:  read_mux = error_reg;
         REG_COUNT:  read_mux = count_reg;
         REG_SECTOR: read_mux = sector_reg;
         REG_CYL_LO: read_mux = cyl_lo_reg;
         REG_CYL_HI: read_mux = cyl_hi_reg;
         REG_HEAD:   read_mux = head_reg;
         REG_STATUS: read_mux = status_byte(bsy, drq, err_reg);
         default:    read_mux = 8'h00;
      endcase
   end

   assign data_out = rd_strobe ? read_mux : 8'hzz;

endmodule

// File: tb/tb_ide_drive.sv
// -----------------------------------------------------------------------------
// tb_ide_drive
// Directed bench for ide_drive (SECTORS=4, BUSY_CYCLES=2, built-in pattern).
// The read bus carries weak pull-ups so an undriven bus reads as 8'hFF.
// -----------------------------------------------------------------------------
module tb_ide_drive;
   import ide_pkg::*;

   logic       clk = 1'b0;
   logic       arst = 1'b1;
   logic       ce_n = 1'b1;
   logic       oe_n = 1'b1;
   logic       we_n = 1'b1;
   logic [2:0] address = 3'd0;
   logic [7:0] data_in = 8'h00;
   wire  [7:0] data_out;

   int n_checks = 0;
   int n_pass   = 0;

   for (genvar gi = 0; gi < 8; gi++) begin : g_pull
      pullup (data_out[gi]);
   end

   always #50 clk = ~clk;

   ide_drive #(
      .SECTORS     (4),
      .BUSY_CYCLES (2),
      .INIT_FILE   ("")
   ) dut (
      .clk      (clk),
      .arst     (arst),
      .ce_n     (ce_n),
      .oe_n     (oe_n),
      .we_n     (we_n),
      .address  (address),
      .data_in  (data_in),
      .data_out (data_out)
   );

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   // Combinational register read with no clock edge under the strobe
   task automatic peek(input logic [2:0] a, output logic [7:0] v);
      address = a;
      ce_n = 1'b0;
      oe_n = 1'b0;
      #1;
      v = data_out;
      ce_n = 1'b1;
      oe_n = 1'b1;
   endtask

   task automatic peek_check(input string tag, input logic [2:0] a, input logic [7:0] exp);
      logic [7:0] v;
      peek(a, v);
      check(tag, 16'(v), 16'(exp));
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [7:0] v);
      @(negedge clk);
      address = a;
      data_in = v;
      ce_n = 1'b0;
      we_n = 1'b0;
      @(negedge clk);
      ce_n = 1'b1;
      we_n = 1'b1;
   endtask

   task automatic issue(input logic [7:0] cmd);
      bus_write(REG_COMMAND, cmd);
      $display("txn: command 0x%02h issued", cmd);
   endtask

   // Counts BSY cycles after a command or a sector boundary, then expects DRQ
   task automatic wait_drq(input int exp_busy);
      int n;
      logic [7:0] s;
      n = 0;
      peek(REG_STATUS, s);
      while (s[7] && n < 40) begin
         @(negedge clk);
         n++;
         peek(REG_STATUS, s);
      end
      check("busy_cycles", 16'(n), 16'(exp_busy));
      check("drq_status", 16'(s), 16'(8'h48));
   endtask

   // Holds the read strobe on the data register for a whole sector
   task automatic read_sector(input int lba, input bit use_fill, input logic [7:0] fill);
      logic [7:0] exp;
      for (int i = 0; i < 512; i++) begin
         @(negedge clk);
         address = REG_DATA;
         ce_n = 1'b0;
         oe_n = 1'b0;
         #1;
         exp = use_fill ? fill : (8'(i) ^ 8'(lba));
         check("read_byte", 16'(data_out), 16'(exp));
      end
      @(negedge clk);
      #1;
      check("data_after_sector", 16'(data_out), 16'(8'h00));
      ce_n = 1'b1;
      oe_n = 1'b1;
      $display("txn: sector %0d read", lba);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---------------- reset values
      repeat (2) @(negedge clk);
      arst = 1'b0;
      @(negedge clk);
      peek_check("rst_status",  REG_STATUS, 8'h40);
      peek_check("rst_error",   REG_ERROR,  8'h01);
      peek_check("rst_count",   REG_COUNT,  8'h01);
      peek_check("rst_sector",  REG_SECTOR, 8'h01);
      peek_check("rst_cyl_lo",  REG_CYL_LO, 8'h00);
      peek_check("rst_cyl_hi",  REG_CYL_HI, 8'h00);
      peek_check("rst_head",    REG_HEAD,   8'hE0);
      peek_check("rst_data",    REG_DATA,   8'h00);
      #1;
      check("bus_released", 16'(data_out), 16'(8'hFF));
      ce_n = 1'b0;
      #1;
      check("bus_released_oe_high", 16'(data_out), 16'(8'hFF));
      ce_n = 1'b1;
      $display("txn: reset values checked");

      // ---------------- single sector at reset LBA 1
      issue(CMD_READ_SECTORS);
      wait_drq(2);
      read_sector(1, 1'b0, 8'h00);
      peek_check("s1_status", REG_STATUS, 8'h40);
      peek_check("s1_sector", REG_SECTOR, 8'h02);
      peek_check("s1_count",  REG_COUNT,  8'h00);

      // ---------------- two sectors from LBA 0
      bus_write(REG_COUNT, 8'h02);
      bus_write(REG_SECTOR, 8'h00);
      issue(CMD_READ_SECTORS);
      wait_drq(2);
      read_sector(0, 1'b0, 8'h00);
      wait_drq(2);
      read_sector(1, 1'b0, 8'h00);
      peek_check("m2_status", REG_STATUS, 8'h40);
      peek_check("m2_sector", REG_SECTOR, 8'h02);
      peek_check("m2_count",  REG_COUNT,  8'h00);

      // ---------------- out-of-range LBA
      bus_write(REG_SECTOR, 8'h07);
      issue(CMD_READ_SECTORS);
      peek_check("idnf_status", REG_STATUS, 8'h41);
      peek_check("idnf_error",  REG_ERROR,  8'h10);
      repeat (4) @(negedge clk);
      peek_check("idnf_no_drq", REG_STATUS, 8'h41);
      peek_check("idnf_data",   REG_DATA,   8'h00);

      // ---------------- unknown command
      issue(8'h91);
      peek_check("abrt_status", REG_STATUS, 8'h41);
      peek_check("abrt_error",  REG_ERROR,  8'h04);

      // ---------------- valid command clears the error; last sector of store
      bus_write(REG_SECTOR, 8'h03);
      bus_write(REG_COUNT, 8'h01);
      issue(CMD_READ_SECTORS);
      peek_check("clr_status_busy", REG_STATUS, 8'h80);
      peek_check("clr_error",       REG_ERROR,  8'h00);
      wait_drq(2);
      read_sector(3, 1'b0, 8'h00);
      peek_check("s3_status", REG_STATUS, 8'h40);
      peek_check("s3_sector", REG_SECTOR, 8'h04);

      // ---------------- writes ignored while BSY, commands ignored while DRQ
      bus_write(REG_SECTOR, 8'h00);
      bus_write(REG_COUNT, 8'h01);
      issue(CMD_READ_SECTORS);
      bus_write(REG_SECTOR, 8'h05);
      peek_check("bsy_write_ignored", REG_SECTOR, 8'h00);
      peek_check("drq_status_now",    REG_STATUS, 8'h48);
      issue(8'h91);
      peek_check("drq_cmd_ignored",   REG_STATUS, 8'h48);
      peek_check("drq_cmd_error",     REG_ERROR,  8'h00);
      read_sector(0, 1'b0, 8'h00);
      peek_check("s0_status", REG_STATUS, 8'h40);

      // ---------------- WRITE SECTORS
`ifdef IDE_WRITE_EN
      bus_write(REG_SECTOR, 8'h02);
      bus_write(REG_COUNT, 8'h01);
      issue(CMD_WRITE_SECTORS);
      wait_drq(2);
      for (int i = 0; i < 512; i++) begin
         @(negedge clk);
         address = REG_DATA;
         data_in = 8'hA5;
         ce_n = 1'b0;
         we_n = 1'b0;
      end
      @(negedge clk);
      ce_n = 1'b1;
      we_n = 1'b1;
      $display("txn: sector 2 written");
      peek_check("wr_status", REG_STATUS, 8'h40);
      peek_check("wr_sector", REG_SECTOR, 8'h03);
      bus_write(REG_SECTOR, 8'h02);
      bus_write(REG_COUNT, 8'h01);
      issue(CMD_READ_SECTORS);
      wait_drq(2);
      read_sector(2, 1'b1, 8'hA5);
`else
      issue(CMD_WRITE_SECTORS);
      peek_check("wr_abrt_status", REG_STATUS, 8'h41);
      peek_check("wr_abrt_error",  REG_ERROR,  8'h04);
`endif

      // ---------------- reset in the middle of a transfer
      bus_write(REG_SECTOR, 8'h02);
      bus_write(REG_COUNT, 8'h03);
      issue(CMD_READ_SECTORS);
      wait_drq(2);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         address = REG_DATA;
         ce_n = 1'b0;
         oe_n = 1'b0;
      end
      @(negedge clk);
      ce_n = 1'b1;
      oe_n = 1'b1;
      arst = 1'b1;
      #1;
      peek_check("arst_status", REG_STATUS, 8'h40);
      peek_check("arst_error",  REG_ERROR,  8'h01);
      peek_check("arst_count",  REG_COUNT,  8'h01);
      peek_check("arst_sector", REG_SECTOR, 8'h01);
      @(negedge clk);
      arst = 1'b0;
      peek_check("arst_data", REG_DATA, 8'h00);
      $display("txn: reset during transfer");

      // Store contents survive the reset
      issue(CMD_READ_SECTORS);
      wait_drq(2);
      read_sector(1, 1'b0, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
